trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Retirement trace buffer sitting directly downstream of the CPU core's debug outputs (PC, instruction, ALU result).
- Continuously records retired-instruction tuples into a circular buffer once armed, and freezes on a PC-match or forced trigger after a programmable post-trigger window.
- Frozen contents are then drained oldest-first over a valid/ready readout port toward a debug host or UART bridge.

Parameters:
- DATA_WIDTH, 32, width of each traced field (pc, instr, alu).
- DEPTH, 16, number of entries; must be a power of 2, at least 4.
- CNT_W, $clog2(DEPTH), localparam: pointer width; count and post fields are CNT_W+1 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trace_valid  in  1  retirement strobe (tie 1 for the single-cycle core)
- trace_pc  in  DATA_WIDTH  retired PC
- trace_instr  in  DATA_WIDTH  retired instruction
- trace_alu  in  DATA_WIDTH  retired ALU result
- arm  in  1  pulse: clear buffer and start capture
- trig_en  in  1  enable PC-match trigger
- trig_pc  in  DATA_WIDTH  trigger PC
- force_trig  in  1  pulse: trigger unconditionally on the next write
- post_count  in  CNT_W+1  entries to capture after the trigger entry
- rd_valid  out  1  readout entry available
- rd_ready  in  1  host accepts entry
- rd_pc  out  DATA_WIDTH  readout PC
- rd_instr  out  DATA_WIDTH  readout instruction
- rd_alu  out  DATA_WIDTH  readout ALU result
- rd_last  out  1  current readout entry is the final one
- busy  out  1  state is PRE or POST
- done  out  1  state is DONE
- entries  out  CNT_W+1  valid entries captured
- trig_idx  out  CNT_W  readout-order index of the trigger entry

Behaviour:
- Reset (synchronous, active-high): state IDLE; all pointers and counters 0; all outputs 0.
- Reset mid-capture or mid-readout discards the buffer.
- States: IDLE, PRE, POST, DONE.
- arm in any state goes to PRE; it clears wr_ptr, entries and the post counter and cancels any readout. arm wins over a same-cycle trigger or rd handshake.
- A write occurs when trace_valid is high in PRE or POST:
  - the entry is stored at wr_ptr, and wr_ptr increments modulo DEPTH;
  - entries increments and saturates at DEPTH (older entries are overwritten).
- Trigger condition in PRE: trace_valid && ((trig_en && trace_pc == trig_pc) || force_trig_pending).
  - force_trig is latched as pending until consumed by a write.
  - The trigger entry is written that cycle, and its physical slot is recorded.
- post_eff = min(post_count, DEPTH-1), sampled on the trigger cycle, so the trigger entry is never overwritten.
  - post_eff==0: go straight to DONE.
  - Otherwise go to POST with the remaining counter = post_eff.
- POST: each write decrements the remaining counter; the write that brings it to 0 moves to DONE in the following cycle. No further writes occur in DONE.
- Triggers in POST are ignored.
- DONE readout:
  - oldest slot = (entries==DEPTH) ? wr_ptr : 0, and rd_ptr is loaded with it on entry to DONE;
  - trig_idx = (trig_slot - oldest) mod DEPTH, valid while done is high;
  - rd_valid = done && remaining_read != 0; rd_* are driven combinationally from the slot at rd_ptr;
  - rd_last = rd_valid && remaining_read==1;
  - on rd_valid && rd_ready, rd_ptr increments (wraps), and after the last entry is accepted the state goes to IDLE;
  - rd_* data must stay stable while rd_valid && !rd_ready.
- entries holds its value through readout and clears on the return to IDLE.
- arm with trig_en=0 and no force_trig: captures indefinitely in PRE (circular).

Optional Feature:
- Macro: TRACE_NOP_FILTER_EN.
- Defined: entries whose trace_instr == 32'h00000013 (canonical NOP) are not written, count nothing, and cannot trigger; a NOP cycle also does not consume force_trig_pending.
- Undefined: every valid cycle is written.

Decomposition:
- Shared package / defines.vh: state encoding constants (ST_IDLE, ST_PRE, ST_POST, ST_DONE) and the NOP encoding constant.
- One natural sub-module, trace_ram: DEPTH x (3*DATA_WIDTH) storage with a synchronous write port and an asynchronous read port.
- Control FSM, pointers and counters stay in trace_capture.

Test Plan:
- DEPTH=16, arm, trig_pc=0x40, post_count=3, PCs 0x00,0x04,... -> DONE 4 cycles after 0x40; entries=16; first rd_pc=0x10; trig_idx=12; rd_last on rd_pc=0x4C.
- arm, trig on the 3rd retired PC (0x08), post_count=2 -> entries=5, first rd_pc=0x00, trig_idx=2, five handshakes then IDLE.
- post_count=20 -> clamped to 15: entries=16, trig_idx=0, first rd_pc=trigger PC.
- Hold rd_ready=0 for 5 cycles mid-readout -> rd_* stable and rd_valid high; arm during readout -> rd_valid=0 next cycle, state PRE, entries=0.
- force_trig pulsed while trace_valid=0, valid asserted 3 cycles later -> that entry is the trigger; same-cycle arm+PC match -> remains PRE, no trigger.
- With TRACE_NOP_FILTER_EN: stream 0x13,0x00500093,0x13 with trigger on the 2nd PC -> entries=1, and only instr 0x00500093 is read out.

Source files
------------

// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - shared state encoding and trace constants
// Contents:
//   state_t    : capture FSM states ST_IDLE, ST_PRE, ST_POST, ST_DONE
//   NOP_INSTR  : canonical RISC-V NOP (addi x0,x0,0), used by the optional NOP filter
package trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/trace_capture_ram.sv
// rtl/trace_capture_ram.sv - trace entry storage, sync write / async read
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   packed {pc, instr, alu}
//   raddr  in   read slot
//   rdata  out  packed {pc, instr, alu} at raddr (combinational)
module trace_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int CNT_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [CNT_W-1:0]        waddr,
    input  logic [3*DATA_WIDTH-1:0] wdata,
    input  logic [CNT_W-1:0]        raddr,
    output logic [3*DATA_WIDTH-1:0] rdata
);

    // Contents are meaningless until written; the controller never presents
    // an unwritten slot as valid, so the array carries no reset.
    logic [3*DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - retirement trace buffer with PC/forced trigger and readout
// Build option: TRACE_NOP_FILTER_EN drops canonical NOPs before they reach the buffer.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   trace_valid/pc/instr/alu           retired-instruction tuple from the core
//   arm                                pulse: clear buffer, start capture
//   trig_en, trig_pc                   PC-match trigger
//   force_trig                         pulse: trigger on the next written entry
//   post_count                         entries to keep after the trigger entry
//   rd_valid/ready/pc/instr/alu/last   oldest-first readout stream
//   busy, done                         capture in progress / buffer frozen
//   entries                            valid entries captured
//   trig_idx                           readout-order position of the trigger entry
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int CNT_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trace_valid,
    input  logic [DATA_WIDTH-1:0] trace_pc,
    input  logic [DATA_WIDTH-1:0] trace_instr,
    input  logic [DATA_WIDTH-1:0] trace_alu,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_pc,
    input  logic                  force_trig,
    input  logic [CNT_W:0]        post_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_pc,
    output logic [DATA_WIDTH-1:0] rd_instr,
    output logic [DATA_WIDTH-1:0] rd_alu,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W:0]        entries,
    output logic [CNT_W-1:0]      trig_idx
);

    localparam logic [CNT_W:0] DEPTH_C  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] MAX_POST = (CNT_W+1)'(DEPTH - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wr_ptr, rd_ptr, trig_slot;
    logic [CNT_W:0]          post_rem, rd_rem;
    logic                    force_pend;

    logic                    is_nop, wr_en, trig_hit, rd_fire, enter_done;
    logic [CNT_W-1:0]        wr_ptr_inc, oldest, oldest_nxt;
    logic [CNT_W:0]          entries_inc, post_eff;
    logic [3*DATA_WIDTH-1:0] ram_rdata;

`ifdef TRACE_NOP_FILTER_EN
    assign is_nop = (trace_instr == DATA_WIDTH'(NOP_INSTR));
`else
    assign is_nop = 1'b0;
`endif

    // arm takes priority: no entry is written on the arm cycle itself.
    assign wr_en    = (state == ST_PRE || state == ST_POST) && trace_valid && !arm && !is_nop;
    assign trig_hit = wr_en && (state == ST_PRE) &&
                      ((trig_en && trace_pc == trig_pc) || force_pend || force_trig);
    // Capping at DEPTH-1 guarantees the trigger entry survives the post window.
    assign post_eff    = (post_count > MAX_POST) ? MAX_POST : post_count;
    assign wr_ptr_inc  = wr_ptr + 1'b1;
    assign entries_inc = (entries == DEPTH_C) ? entries : entries + 1'b1;
    assign rd_fire     = rd_valid && rd_ready;

    // Entry into DONE always coincides with a write, so the oldest slot is
    // computed from the post-write pointer and count.
    assign oldest_nxt = (entries_inc == DEPTH_C) ? wr_ptr_inc : '0;
    assign oldest     = (entries == DEPTH_C) ? wr_ptr : '0;

    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ST_PRE;
        end else begin
            case (state)
                ST_PRE:  if (trig_hit) state_nxt = (post_eff == '0) ? ST_DONE : ST_POST;
                ST_POST: if (wr_en && post_rem == 1) state_nxt = ST_DONE;
                ST_DONE: if (rd_fire && rd_rem == 1) state_nxt = ST_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    assign enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trig_slot  <= '0;
            entries    <= '0;
            post_rem   <= '0;
            rd_rem     <= '0;
            force_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (arm) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                entries    <= '0;
                post_rem   <= '0;
                rd_rem     <= '0;
                force_pend <= 1'b0;
            end else begin
                // Any written entry consumes a pending force (it either
                // triggered in PRE or was meaningless in POST).
                force_pend <= wr_en ? 1'b0 : (force_pend | force_trig);
                if (wr_en) begin
                    wr_ptr  <= wr_ptr_inc;
                    entries <= entries_inc;
                    if (state == ST_POST) post_rem <= post_rem - 1'b1;
                end
                if (trig_hit) begin
                    trig_slot <= wr_ptr;
                    post_rem  <= post_eff;
                end
                if (enter_done) begin
                    rd_ptr <= oldest_nxt;
                    rd_rem <= entries_inc;
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_rem <= rd_rem - 1'b1;
                    if (rd_rem == 1) entries <= '0;
                end
            end
        end
    end

    trace_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({trace_pc, trace_instr, trace_alu}),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign busy     = (state == ST_PRE) || (state == ST_POST);
    assign done     = (state == ST_DONE);
    assign rd_valid = done && (rd_rem != '0);
    assign rd_last  = rd_valid && (rd_rem == 1);
    // Data is gated so idle outputs read as zero rather than stale RAM.
    assign rd_pc    = rd_valid ? ram_rdata[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;
    assign rd_instr = rd_valid ? ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH]   : '0;
    assign rd_alu   = rd_valid ? ram_rdata[DATA_WIDTH-1:0]              : '0;
    assign trig_idx = done ? (trig_slot - oldest) : '0;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - directed self-checking bench for trace_capture
module tb_trace_capture;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_valid;
    logic [31:0] trace_pc, trace_instr, trace_alu;
    logic        arm, trig_en, force_trig, rd_ready;
    logic [31:0] trig_pc;
    logic [4:0]  post_count;
    logic        rd_valid, rd_last, busy, done;
    logic [31:0] rd_pc, rd_instr, rd_alu;
    logic [4:0]  entries;
    logic [3:0]  trig_idx;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    trace_capture #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_alu(trace_alu),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig), .post_count(post_count),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu),
        .rd_last(rd_last), .busy(busy), .done(done), .entries(entries), .trig_idx(trig_idx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        trace_valid = v;
        trace_pc    = pc;
        trace_instr = instr;
        trace_alu   = pc + 32'd1;
    endtask

    task automatic do_arm(input logic en, input logic [31:0] tpc, input logic [4:0] pcnt);
        @(negedge clk);
        trig_en = en; trig_pc = tpc; post_count = pcnt; arm = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Arms, streams PCs 0,4,8,... until done; checks the write count.
    task automatic capture(input string tag, input logic [31:0] tpc, input logic [4:0] pcnt,
                           input int n_writes);
        logic [31:0] pc;
        int          n;
        do_arm(1'b1, tpc, pcnt);
        pc = 0; n = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, pc, pc ^ K);
            @(negedge clk);
            n++;
            if (done) break;
            pc += 4;
        end
        drive(1'b0, 32'h0, 32'h0);
        check({tag, " done"}, done, 1);
        check({tag, " writes"}, n, n_writes);
    endtask

    task automatic drain(input string tag, input int n_exp, input logic [31:0] first_pc,
                         input logic [31:0] last_pc, input int tidx, input logic [31:0] first_instr);
        int          cnt;
        logic [31:0] prev, lastseen;
        logic        ok;
        check({tag, " entries"}, entries, n_exp);
        check({tag, " trig_idx"}, trig_idx, tidx);
        check({tag, " first pc"}, rd_pc, first_pc);
        check({tag, " first instr"}, rd_instr, first_instr);
        check({tag, " first alu"}, rd_alu, first_pc + 1);
        rd_ready = 1'b1;
        cnt = 0; prev = 0; lastseen = 32'hFFFF_FFFF; ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!rd_valid) break;
            if (cnt > 0 && rd_pc != prev + 4) ok = 1'b0;
            prev = rd_pc;
            if (rd_last) lastseen = rd_pc;
            cnt++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check({tag, " handshakes"}, cnt, n_exp);
        check({tag, " order"}, ok, 1);
        check({tag, " last pc"}, lastseen, last_pc);
        check({tag, " idle"}, {busy, done}, 2'b00);
        check({tag, " entries clr"}, entries, 0);
    endtask

    initial begin
        logic [31:0] held;
        logic        stable;

        reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = 0; force_trig = 1'b0;
        post_count = 0; rd_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst outputs", {rd_valid, rd_last, busy, done}, 4'b0000);
        check("rst entries", entries, 0);
        check("rst trig_idx", trig_idx, 0);
        check("rst rd_pc", rd_pc, 0);

        // wrap: 20 writes, trigger at slot 0
        capture("t1", 32'h40, 5'd3, 20);
        drain("t1", 16, 32'h10, 32'h4C, 12, 32'h10 ^ K);

        // short capture, no wrap
        capture("t2", 32'h08, 5'd2, 5);
        drain("t2", 5, 32'h00, 32'h10, 2, 32'h0 ^ K);

        // post_count clamp to 15
        capture("t3", 32'h08, 5'd20, 18);
        drain("t3", 16, 32'h08, 32'h44, 0, 32'h08 ^ K);

        // back-pressure, then arm during readout
        capture("t4", 32'h08, 5'd2, 5);
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rd_ready = 1'b0;
        held = rd_pc; stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_pc != held || !rd_valid) stable = 1'b0;
        end
        check("t4 hold stable", stable, 1);
        check("t4 hold pc", rd_pc, 32'h08);
        check("t4 hold valid", rd_valid, 1);
        arm = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        arm = 1'b0; rd_ready = 1'b0;
        check("t4 arm valid", rd_valid, 0);
        check("t4 arm state", {busy, done}, 2'b10);
        check("t4 arm entries", entries, 0);

        // forced trigger while trace_valid low, consumed 3 cycles later
        do_arm(1'b0, 32'h0, 5'd1);
        drive(1'b1, 32'h00, 32'h00 ^ K); @(negedge clk);
        drive(1'b1, 32'h04, 32'h04 ^ K); @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        force_trig = 1'b1; @(negedge clk);
        force_trig = 1'b0; repeat (2) @(negedge clk);
        check("t5 pending busy", {busy, done}, 2'b10);
        drive(1'b1, 32'h08, 32'h08 ^ K); @(negedge clk);
        check("t5 post state", {busy, done}, 2'b10);
        drive(1'b1, 32'h0C, 32'h0C ^ K); @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("t5 done", done, 1);
        drain("t5", 4, 32'h00, 32'h0C, 2, 32'h00 ^ K);

        // arm with a same-cycle PC match does not trigger
        @(negedge clk);
        trig_en = 1'b1; trig_pc = 32'h200; post_count = 0; arm = 1'b1;
        drive(1'b1, 32'h200, 32'h200 ^ K);
        @(negedge clk);
        arm = 1'b0;
        check("t6 arm+match state", {busy, done}, 2'b10);
        check("t6 arm+match entries", entries, 0);
        drive(1'b1, 32'h204, 32'h204 ^ K); @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("t6 next write", entries, 1);
        check("t6 still pre", {busy, done}, 2'b10);

        // NOP stream
        do_arm(1'b1, 32'h04, 5'd0);
        drive(1'b1, 32'h00, 32'h0000_0013); @(negedge clk);
        drive(1'b1, 32'h04, 32'h0050_0093); @(negedge clk);
        drive(1'b1, 32'h08, 32'h0000_0013); @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("t7 done", done, 1);
`ifdef TRACE_NOP_FILTER_EN
        drain("t7", 1, 32'h04, 32'h04, 0, 32'h0050_0093);
`else
        drain("t7", 2, 32'h00, 32'h04, 1, 32'h0000_0013);
`endif

        // reset while frozen discards the buffer
        capture("t8", 32'h08, 5'd2, 5);
        reset = 1'b1; @(negedge clk);
        reset = 1'b0;
        check("t8 rst state", {rd_valid, busy, done}, 3'b000);
        check("t8 rst entries", entries, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
